// File: rtl/rr_onehot_scheduler.sv
// Round-robin scheduler: one registered one-hot grant at a time, offset-binary
// grant code of the winner, hold-time limit with a timeout pulse on expiry.
module rr_onehot_scheduler #(
    parameter int INPUTS   = 8,
    parameter int WIDTH    = 8,
    parameter int OFFSET   = 54,
    parameter int MAX_HOLD = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [INPUTS-1:0] req,
    output logic [INPUTS-1:0] grant,
    output logic              grant_valid,
    output logic [WIDTH-1:0]  grant_code,
    output logic              timeout
);

    localparam int IW = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [IW-1:0] LAST_IDX = IW'(INPUTS - 1);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    function automatic logic [WIDTH-1:0] code_of(input logic [IW-1:0] idx);
        return WIDTH'(OFFSET) + WIDTH'(idx);
    endfunction

    // Returns {found, index}; scanned farthest-first so the bit nearest ptr wins.
    function automatic logic [IW:0] rr_pick(input logic [INPUTS-1:0] r,
                                            input logic [IW-1:0]     p);
        logic [IW:0] res;
        int          j;
        res = '0;
        for (int k = INPUTS - 1; k >= 0; k--) begin
            j = int'(p) + k;
            if (j >= INPUTS) j = j - INPUTS;
            if (r[IW'(j)]) res = {1'b1, IW'(j)};
        end
        return res;
    endfunction

    state_t            state_q, state_d;
    logic [INPUTS-1:0] grant_q, grant_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  code_q, code_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic [IW:0]       pick;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        pick      = rr_pick(req, ptr_q);
        case (state_q)
            ST_IDLE: begin
                if (enable && pick[IW]) begin
                    state_d = ST_GRANT;
                    idx_d   = pick[IW-1:0];
                    grant_d = INPUTS'(1) << pick[IW-1:0];
                    cnt_d   = CW'(1);
                end
            end
            ST_GRANT: begin
                // Only the winner's own request line matters during a tenure.
                if (!req[idx_q] || (MAX_HOLD != 0 && cnt_q == HOLD_MAX)) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    cnt_d     = '0;
                    ptr_d     = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
                    timeout_d = req[idx_q];
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_GRANT);
        code_d  = valid_d ? code_of(idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_code  = code_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_onehot_scheduler.sv
// Directed bench for rr_onehot_scheduler: default build, MAX_HOLD=3 build and
// OFFSET=254 build share the stimulus; each phase checks the relevant instance.
module tb_rr_onehot_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] req;

    logic [7:0] a_grant, f_grant, w_grant;
    logic       a_valid, f_valid, w_valid;
    logic [7:0] a_code, f_code, w_code;
    logic       a_to, f_to, w_to;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_onehot_scheduler #(.INPUTS(8), .WIDTH(8), .OFFSET(54), .MAX_HOLD(15)) ua (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
        .grant(a_grant), .grant_valid(a_valid), .grant_code(a_code), .timeout(a_to));

    rr_onehot_scheduler #(.INPUTS(8), .WIDTH(8), .OFFSET(54), .MAX_HOLD(3)) uf (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
        .grant(f_grant), .grant_valid(f_valid), .grant_code(f_code), .timeout(f_to));

    rr_onehot_scheduler #(.INPUTS(8), .WIDTH(8), .OFFSET(254), .MAX_HOLD(15)) uw (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
        .grant(w_grant), .grant_valid(w_valid), .grant_code(w_code), .timeout(w_to));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
            $error("mismatch on %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [7:0] g, input logic [7:0] c,
                         input logic to);
        check({tag, ".grant"}, a_grant, g);
        check({tag, ".valid"}, a_valid, (g != 8'h00));
        check({tag, ".code"}, a_code, c);
        check({tag, ".timeout"}, a_to, to);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running, expected done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_g;

        // Reset with all requests asserted
        rst_n  = 1'b0;
        enable = 1'b1;
        req    = 8'hFF;
        tick();
        tick();
        chk_a("reset", 8'h00, 8'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_a("first_grant", 8'h01, 8'd54, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_a("reset_mid_grant", 8'h00, 8'd0, 1'b0);
        rst_n = 1'b1;
        req   = 8'h00;
        tick();
        chk_a("idle_no_req", 8'h00, 8'd0, 1'b0);

        // Rotation
        req = 8'b0000_0101;
        tick();
        chk_a("rot_g0", 8'h01, 8'd54, 1'b0);
        tick();
        chk_a("rot_g0_hold", 8'h01, 8'd54, 1'b0);
        req = 8'h04;
        tick();
        chk_a("rot_rel0", 8'h00, 8'd0, 1'b0);
        tick();
        chk_a("rot_g2", 8'h04, 8'd56, 1'b0);
        req = 8'h01;
        tick();
        chk_a("rot_rel2", 8'h00, 8'd0, 1'b0);
        tick();
        chk_a("rot_g0_again", 8'h01, 8'd54, 1'b0);
        req = 8'h00;
        tick();
        chk_a("rot_rel_final", 8'h00, 8'd0, 1'b0);

        // Timeout at MAX_HOLD=15
        req = 8'h80;
        tick();
        chk_a("to_start", 8'h80, 8'd61, 1'b0);
        for (int i = 1; i < 15; i++) begin
            tick();
            check("to_hold.grant", a_grant, 8'h80);
            check("to_hold.timeout", a_to, 1'b0);
        end
        tick();
        chk_a("to_expire", 8'h00, 8'd0, 1'b1);
        tick();
        chk_a("to_regrant", 8'h80, 8'd61, 1'b0);
        req = 8'h00;
        tick();
        chk_a("to_release", 8'h00, 8'd0, 1'b0);

        // Fairness, MAX_HOLD=3 instance
        do_reset();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_g = 8'h01 << (k % 8);
            for (int c = 0; c < 3; c++) begin
                tick();
                check("fair.grant", f_grant, exp_g);
                check("fair.code", f_code, 8'(54 + (k % 8)));
                check("fair.timeout", f_to, 1'b0);
            end
            tick();
            check("fair_gap.grant", f_grant, 8'h00);
            check("fair_gap.timeout", f_to, 1'b1);
        end
        req = 8'h00;
        tick();

        // Enable gating
        do_reset();
        enable = 1'b0;
        req    = 8'h10;
        tick();
        chk_a("en_off_1", 8'h00, 8'd0, 1'b0);
        tick();
        chk_a("en_off_2", 8'h00, 8'd0, 1'b0);
        enable = 1'b1;
        tick();
        chk_a("en_grant", 8'h10, 8'd58, 1'b0);
        enable = 1'b0;
        tick();
        chk_a("en_drop_1", 8'h10, 8'd58, 1'b0);
        tick();
        chk_a("en_drop_2", 8'h10, 8'd58, 1'b0);
        req = 8'h00;
        tick();
        chk_a("en_release", 8'h00, 8'd0, 1'b0);
        enable = 1'b1;

        // Code wrap with OFFSET=254
        do_reset();
        req = 8'h08;
        tick();
        check("wrap.grant", w_grant, 8'h08);
        check("wrap.code", w_code, 8'd1);
        check("wrap.valid", w_valid, 1'b1);
        check("wrap.ref_code", a_code, 8'd57);
        req = 8'h00;
        tick();
        check("wrap.idle_code", w_code, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
